// File: rtl/traffic_seq_ctrl_if.sv
// Host configuration and register-file port bundle for traffic_seq_ctrl.
// The master side is the host/register file; the slave side is the sequencer.
interface traffic_seq_ctrl_if #(
  parameter int unsigned data_width = 3,
  parameter int unsigned reg_width  = 2
);
  logic                  cfg_we;
  logic [reg_width-1:0]  cfg_addr;
  logic [data_width-1:0] cfg_data;

  logic [data_width-1:0] rf_data_in;
  logic [reg_width-1:0]  rf_WA;
  logic                  rf_WEn;
  logic                  rf_REA;
  logic [reg_width-1:0]  rf_RAA;
  logic [data_width-1:0] rf_outA;
  logic                  rf_REB;
  logic [reg_width-1:0]  rf_RAB;

  modport master (
    output cfg_we, cfg_addr, cfg_data, rf_outA,
    input  rf_data_in, rf_WA, rf_WEn, rf_REA, rf_RAA, rf_REB, rf_RAB
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, rf_outA,
    output rf_data_in, rf_WA, rf_WEn, rf_REA, rf_RAA, rf_REB, rf_RAB
  );
endinterface

// File: rtl/traffic_seq_ctrl.sv
// Two-road traffic-light sequencer: fetches each phase duration from the register
// file over port A, counts it down on an external tick, and forwards host writes.
module traffic_seq_ctrl #(
  parameter int unsigned data_width = 3,
  parameter int unsigned reg_width  = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                run,
  input  logic                tick,
  traffic_seq_ctrl_if.slave   bus,
  output logic [2:0]          ns_light,
  output logic [2:0]          ew_light,
  output logic [2:0]          phase
);

  localparam logic [2:0] LightR = 3'b100;
  localparam logic [2:0] LightY = 3'b010;
  localparam logic [2:0] LightG = 3'b001;
  localparam logic [2:0] LastPhase = 3'd5;

  typedef enum logic [1:0] {StIdle, StFetch, StLoad, StCount} state_e;

  state_e                r_state, w_state_nxt;
  logic [2:0]            r_phase, w_phase_nxt;
  logic [data_width-1:0] r_cnt, w_cnt_nxt;
  logic                  r_rea, w_rea_nxt;
  logic [reg_width-1:0]  r_raa, w_raa_nxt;
  logic [2:0]            r_ns, w_ns_nxt;
  logic [2:0]            r_ew, w_ew_nxt;

  // Duration register used by each phase; both yellows share rf[1], both all-reds rf[2].
  function automatic logic [reg_width-1:0] phase_index(input logic [2:0] p);
    logic [reg_width-1:0] idx;
    case (p)
      3'd0:    idx = reg_width'(0);
      3'd1:    idx = reg_width'(1);
      3'd2:    idx = reg_width'(2);
      3'd3:    idx = reg_width'(3);
      3'd4:    idx = reg_width'(1);
      3'd5:    idx = reg_width'(2);
      default: idx = reg_width'(0);
    endcase
    return idx;
  endfunction

  // Returns {ns, ew}; unreachable phases fall back to all-red.
  function automatic logic [5:0] phase_lights(input logic [2:0] p);
    logic [5:0] l;
    case (p)
      3'd0:    l = {LightG, LightR};
      3'd1:    l = {LightY, LightR};
      3'd2:    l = {LightR, LightR};
      3'd3:    l = {LightR, LightG};
      3'd4:    l = {LightR, LightY};
      3'd5:    l = {LightR, LightR};
      default: l = {LightR, LightR};
    endcase
    return l;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;

    if (!run) begin
      w_state_nxt = StIdle;
      w_phase_nxt = 3'd0;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_state_nxt = StFetch;
          w_phase_nxt = 3'd0;
        end
        StFetch: begin
          w_state_nxt = StLoad;
        end
        StLoad: begin
          // A zero duration still lasts one tick.
          w_cnt_nxt   = (bus.rf_outA == '0) ? data_width'(1) : bus.rf_outA;
          w_state_nxt = StCount;
        end
        StCount: begin
          if (tick) begin
            if (r_cnt > data_width'(1)) begin
              w_cnt_nxt = r_cnt - data_width'(1);
            end else begin
              w_state_nxt = StFetch;
              w_phase_nxt = (r_phase >= LastPhase) ? 3'd0 : r_phase + 3'd1;
            end
          end
        end
        default: begin
          w_state_nxt = StIdle;
          w_phase_nxt = 3'd0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from next-state so lights, phase and the read strobe
  // all change on the edge that enters FETCH.
  always_comb begin
    w_rea_nxt = (w_state_nxt == StFetch);
    w_raa_nxt = r_raa;
    if (w_rea_nxt) begin
      w_raa_nxt = phase_index(w_phase_nxt);
    end
    if (w_state_nxt == StIdle) begin
      w_ns_nxt = LightR;
      w_ew_nxt = LightR;
    end else begin
      {w_ns_nxt, w_ew_nxt} = phase_lights(w_phase_nxt);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= StIdle;
      r_phase <= 3'd0;
      r_cnt   <= '0;
      r_rea   <= 1'b0;
      r_raa   <= '0;
      r_ns    <= LightR;
      r_ew    <= LightR;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rea   <= w_rea_nxt;
      r_raa   <= w_raa_nxt;
      r_ns    <= w_ns_nxt;
      r_ew    <= w_ew_nxt;
    end
  end

  assign bus.rf_data_in = bus.cfg_data;
  assign bus.rf_WA      = bus.cfg_addr;
  assign bus.rf_WEn     = bus.cfg_we;
  assign bus.rf_REA     = r_rea;
  assign bus.rf_RAA     = r_raa;
  assign bus.rf_REB     = 1'b0;
  assign bus.rf_RAB     = '0;

  assign ns_light = r_ns;
  assign ew_light = r_ew;
  assign phase    = r_phase;

endmodule

// File: tb/tb_traffic_seq_ctrl.sv
// Directed bench for traffic_seq_ctrl with a behavioural 4 x 3-bit register file
// (one-cycle read latency, read-before-write).
module tb_traffic_seq_ctrl;
  localparam int unsigned DW = 3;
  localparam int unsigned RW = 2;

  logic       CLK = 1'b0;
  logic       RST;
  logic       run;
  logic       tick;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [2:0] phase;

  traffic_seq_ctrl_if #(.data_width(DW), .reg_width(RW)) bus ();

  traffic_seq_ctrl #(.data_width(DW), .reg_width(RW)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .run      (run),
    .tick     (tick),
    .bus      (bus.slave),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .phase    (phase)
  );

  always #5 CLK = ~CLK;

  logic [DW-1:0] rf_mem [4];
  always @(posedge CLK) begin
    if (bus.rf_WEn) rf_mem[bus.rf_WA] <= bus.rf_data_in;
    if (bus.rf_REA) bus.rf_outA <= rf_mem[bus.rf_RAA];
  end

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  bit sparse = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sparse mode: tick high on cycles 1, 5, 9, ... counted from cyc = 0.
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    if (sparse) tick = (cyc % 4 == 1);
  endtask

  task automatic cfg_write(input int a, input int d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a[RW-1:0];
    bus.cfg_data = d[DW-1:0];
    step();
    bus.cfg_we   = 1'b0;
  endtask

  // Called right after the edge entering FETCH; returns right after the next FETCH edge.
  task automatic phase_run(input string tag, input int ph, input logic [2:0] ns,
                           input logic [2:0] ew, input int raa, input int len,
                           input int wr_at, input int wr_addr, input int wr_data);
    int n;
    check({tag, ".phase"}, phase, ph);
    check({tag, ".ns"}, ns_light, ns);
    check({tag, ".ew"}, ew_light, ew);
    check({tag, ".rea"}, bus.rf_REA, 1);
    check({tag, ".raa"}, bus.rf_RAA, raa);
    n = 0;
    do begin
      if (n == wr_at) begin
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = wr_addr[RW-1:0];
        bus.cfg_data = wr_data[DW-1:0];
      end
      step();
      bus.cfg_we = 1'b0;
      n++;
    end while (phase == ph[2:0] && n < 64);
    check({tag, ".len"}, n, len);
  endtask

  task automatic idle_hold(input string tag);
    int pulses;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.rf_REA) pulses++;
    end
    check(tag, pulses, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; run = 1'b0; tick = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    #1 RST = 1'b1;
    step(); step();
    check("rst.ns", ns_light, 3'b100);
    check("rst.ew", ew_light, 3'b100);
    check("rst.phase", phase, 0);
    check("rst.rea", bus.rf_REA, 0);
    check("rst.raa", bus.rf_RAA, 0);
    check("rst.reb", bus.rf_REB, 0);
    check("rst.rab", bus.rf_RAB, 0);
    RST = 1'b0;

    // Combinational write pass-through
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd2; bus.cfg_data = 3'd1;
    #1;
    check("pass.data", bus.rf_data_in, 1);
    check("pass.wa", bus.rf_WA, 2);
    check("pass.wen", bus.rf_WEn, 1);
    step();
    bus.cfg_we = 1'b0;
    cfg_write(0, 3);
    cfg_write(1, 2);
    cfg_write(3, 4);

    idle_hold("idle.rea_pulses");

    // Run rising: NS green after one edge, then async reset mid-COUNT
    run = 1'b1;
    step();
    check("start.ns", ns_light, 3'b001);
    check("start.rea", bus.rf_REA, 1);
    check("start.raa", bus.rf_RAA, 0);
    step(); step(); step();
    check("count.ns", ns_light, 3'b001);
    RST = 1'b1;
    #1;
    check("midrst.ns", ns_light, 3'b100);
    check("midrst.ew", ew_light, 3'b100);
    check("midrst.phase", phase, 0);
    check("midrst.rea", bus.rf_REA, 0);
    run = 1'b0;
    step();
    RST = 1'b0;
    idle_hold("postrst.rea_pulses");

    // Full cycle, rf = {3,2,1,4}, tick tied high
    tick = 1'b1; run = 1'b1;
    step();
    phase_run("r1p0", 0, 3'b001, 3'b100, 0, 5, -1, 0, 0);
    phase_run("r1p1", 1, 3'b010, 3'b100, 1, 4, -1, 0, 0);
    phase_run("r1p2", 2, 3'b100, 3'b100, 2, 3, -1, 0, 0);
    phase_run("r1p3", 3, 3'b100, 3'b001, 3, 6, -1, 0, 0);
    phase_run("r1p4", 4, 3'b100, 3'b010, 1, 4, -1, 0, 0);
    phase_run("r1p5", 5, 3'b100, 3'b100, 2, 3, 1, 1, 0);
    // Round 2: rf[1]=0; rf[0]=7 written mid NS_G; rf[3]=6 written during EW_G fetch
    phase_run("r2p0", 0, 3'b001, 3'b100, 0, 5, 2, 0, 7);
    phase_run("r2p1", 1, 3'b010, 3'b100, 1, 3, -1, 0, 0);
    phase_run("r2p2", 2, 3'b100, 3'b100, 2, 3, -1, 0, 0);
    phase_run("r2p3", 3, 3'b100, 3'b001, 3, 6, 0, 3, 6);
    phase_run("r2p4", 4, 3'b100, 3'b010, 1, 3, -1, 0, 0);
    phase_run("r2p5", 5, 3'b100, 3'b100, 2, 3, -1, 0, 0);
    phase_run("r3p0", 0, 3'b001, 3'b100, 0, 9, -1, 0, 0);
    phase_run("r3p1", 1, 3'b010, 3'b100, 1, 3, -1, 0, 0);
    phase_run("r3p2", 2, 3'b100, 3'b100, 2, 3, -1, 0, 0);
    phase_run("r3p3", 3, 3'b100, 3'b001, 3, 8, -1, 0, 0);

    // Run drop inside EW_Y
    check("drop.pre_ew", ew_light, 3'b010);
    step(); step();
    run = 1'b0;
    step();
    check("drop.ns", ns_light, 3'b100);
    check("drop.ew", ew_light, 3'b100);
    check("drop.phase", phase, 0);
    check("drop.rea", bus.rf_REA, 0);
    step();
    cfg_write(0, 2);

    // Sparse tick: ticks on LOAD cycle (ignored) and every 4th cycle after
    tick = 1'b0; run = 1'b1;
    step();
    sparse = 1'b1; cyc = 0; tick = 1'b0;
    phase_run("sparse.p0", 0, 3'b001, 3'b100, 0, 10, -1, 0, 0);
    phase_run("sparse.p1", 1, 3'b010, 3'b100, 1, 4, -1, 0, 0);
    sparse = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
